// File: rtl/gpu_sram_arbiter.sv
// gpu_sram_arbiter: shares the gpu_memcontroller pixel port between two pixel
// writers and one display reader, and sequences frame flushes
// (drain reads -> flush pulse -> settle hold-off -> acknowledge).
module gpu_sram_arbiter #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 10,
  parameter int CHANNEL_BITS = 8,
  parameter int RD_LAT       = 2,
  parameter int MAX_RD_RUN   = 4,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      wr0_req,
  input  logic [WIDTH_BITS-1:0]     wr0_x,
  input  logic [HEIGHT_BITS-1:0]    wr0_y,
  input  logic [3*CHANNEL_BITS-1:0] wr0_rgb,
  output logic                      wr0_ack,
  input  logic                      wr1_req,
  input  logic [WIDTH_BITS-1:0]     wr1_x,
  input  logic [HEIGHT_BITS-1:0]    wr1_y,
  input  logic [3*CHANNEL_BITS-1:0] wr1_rgb,
  output logic                      wr1_ack,
  input  logic                      rd_req,
  input  logic [WIDTH_BITS-1:0]     rd_x,
  input  logic [HEIGHT_BITS-1:0]    rd_y,
  output logic                      rd_ack,
  output logic                      rd_valid,
  output logic [3*CHANNEL_BITS-1:0] rd_rgb,
  input  logic                      flush_req,
  output logic                      flush_ack,
  output logic                      data_out,
  output logic [CHANNEL_BITS-1:0]   rdata,
  output logic [CHANNEL_BITS-1:0]   gdata,
  output logic [CHANNEL_BITS-1:0]   bdata,
  output logic [WIDTH_BITS-1:0]     adddatax,
  output logic [HEIGHT_BITS-1:0]    adddatay,
  output logic                      flush,
  output logic                      mem_rd,
  input  logic [3*CHANNEL_BITS-1:0] mem_rgb_in
);

  localparam int RGB_W  = 3 * CHANNEL_BITS;
  localparam int RUN_W  = $clog2(MAX_RD_RUN + 1);
  localparam int HOLD_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {ST_ARB, ST_DRAIN, ST_FLUSH, ST_HOLD} state_t;

  state_t                  state, state_d;
  logic [HOLD_W-1:0]       hold_cnt, hold_cnt_d;
  logic [RUN_W-1:0]        run_cnt, run_cnt_d;
  logic                    rr_last, rr_last_d;   // 1: wr1 granted last, so wr0 is favoured
  logic [RD_LAT-1:0]       vld_p;                // vld_p[i] high: read return i+1 cycles after mem_rd

  logic                    wr0_ack_d, wr1_ack_d, rd_ack_d;
  logic                    data_out_d, mem_rd_d, flush_d, flush_ack_d;
  logic [CHANNEL_BITS-1:0] rdata_d, gdata_d, bdata_d;
  logic [WIDTH_BITS-1:0]   adddatax_d;
  logic [HEIGHT_BITS-1:0]  adddatay_d;

  logic                    wr0_elig, wr1_elig, rd_elig, wr_any, run_full, sel_wr1, pipe_empty;
  logic [RGB_W-1:0]        wr_rgb;

  // Saturating increment of the read-run counter.
  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
    if (v == RUN_W'(MAX_RD_RUN)) return v;
    return v + 1'b1;
  endfunction

  // A port whose ack is high this cycle cannot be granted again at the next edge.
  assign wr0_elig   = wr0_req && !wr0_ack;
  assign wr1_elig   = wr1_req && !wr1_ack;
  assign rd_elig    = rd_req && !rd_ack;
  assign wr_any     = wr0_elig || wr1_elig;
  assign run_full   = (run_cnt == RUN_W'(MAX_RD_RUN));
  assign sel_wr1    = wr1_elig && (!wr0_elig || !rr_last);
  assign wr_rgb     = sel_wr1 ? wr1_rgb : wr0_rgb;
  assign pipe_empty = !mem_rd && (vld_p == '0);

  // Next-state and next-output decode: grant selection and flush sequencing.
  always_comb begin
    state_d     = state;
    hold_cnt_d  = hold_cnt;
    run_cnt_d   = run_cnt;
    rr_last_d   = rr_last;
    wr0_ack_d   = 1'b0;
    wr1_ack_d   = 1'b0;
    rd_ack_d    = 1'b0;
    data_out_d  = 1'b0;
    mem_rd_d    = 1'b0;
    flush_d     = 1'b0;
    flush_ack_d = 1'b0;
    rdata_d     = rdata;
    gdata_d     = gdata;
    bdata_d     = bdata;
    adddatax_d  = adddatax;
    adddatay_d  = adddatay;
    case (state)
      ST_ARB: begin
        if (flush_req && !flush_ack) begin
          state_d   = ST_DRAIN;
          run_cnt_d = '0;
        end else if (rd_elig && !(run_full && wr_any)) begin
          rd_ack_d   = 1'b1;
          mem_rd_d   = 1'b1;
          adddatax_d = rd_x;
          adddatay_d = rd_y;
          run_cnt_d  = wr_any ? sat_inc(run_cnt) : '0;
        end else if (wr_any) begin
          wr0_ack_d  = !sel_wr1;
          wr1_ack_d  = sel_wr1;
          rr_last_d  = sel_wr1;
          data_out_d = 1'b1;
          rdata_d    = wr_rgb[RGB_W-1 -: CHANNEL_BITS];
          gdata_d    = wr_rgb[2*CHANNEL_BITS-1 -: CHANNEL_BITS];
          bdata_d    = wr_rgb[CHANNEL_BITS-1:0];
          adddatax_d = sel_wr1 ? wr1_x : wr0_x;
          adddatay_d = sel_wr1 ? wr1_y : wr0_y;
          run_cnt_d  = '0;
        end else begin
          run_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) begin
          state_d = ST_FLUSH;
          flush_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        state_d     = ST_HOLD;
        hold_cnt_d  = HOLD_W'(FLUSH_CYCLES - 1);
        flush_ack_d = (FLUSH_CYCLES == 1);
      end
      default: begin
        if (hold_cnt == '0) begin
          state_d = ST_ARB;
        end else begin
          hold_cnt_d  = hold_cnt - 1'b1;
          flush_ack_d = (hold_cnt == HOLD_W'(1));
        end
      end
    endcase
  end

  // State, counters and all memory-side/grant outputs registered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_ARB;
      hold_cnt  <= '0;
      run_cnt   <= '0;
      rr_last   <= 1'b1;
      wr0_ack   <= 1'b0;
      wr1_ack   <= 1'b0;
      rd_ack    <= 1'b0;
      data_out  <= 1'b0;
      mem_rd    <= 1'b0;
      flush     <= 1'b0;
      flush_ack <= 1'b0;
      rdata     <= '0;
      gdata     <= '0;
      bdata     <= '0;
      adddatax  <= '0;
      adddatay  <= '0;
    end else begin
      state     <= state_d;
      hold_cnt  <= hold_cnt_d;
      run_cnt   <= run_cnt_d;
      rr_last   <= rr_last_d;
      wr0_ack   <= wr0_ack_d;
      wr1_ack   <= wr1_ack_d;
      rd_ack    <= rd_ack_d;
      data_out  <= data_out_d;
      mem_rd    <= mem_rd_d;
      flush     <= flush_d;
      flush_ack <= flush_ack_d;
      rdata     <= rdata_d;
      gdata     <= gdata_d;
      bdata     <= bdata_d;
      adddatax  <= adddatax_d;
      adddatay  <= adddatay_d;
    end
  end

  // Read-return pipe: track mem_rd for RD_LAT cycles, then capture the pixel.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_p    <= '0;
      rd_valid <= 1'b0;
      rd_rgb   <= '0;
    end else begin
      vld_p[0] <= mem_rd;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      rd_valid <= vld_p[RD_LAT-1];
      if (vld_p[RD_LAT-1]) rd_rgb <= mem_rgb_in;
    end
  end

endmodule
